// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; one iteration per clock.
// Optional zero-operand early-out is enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   dsor_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;       // {partial product, multiplier} or {remainder, quotient}
  logic               is_div_q, neg_q, neg_rem_q, dz_q;
  logic               busy_q, done_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               op_div, op_sgn, early;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_d, prod_fix;
  logic [WIDTH:0]     mul_sum, div_top;
  logic [2*WIDTH:0]   div_shl;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  assign op_div = op[1];
  assign op_sgn = ~op[0];
  assign a_mag  = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (op_sgn && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op_div ? (b == '0) : ((a == '0) || (b == '0));
`else
  assign early = 1'b0;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsor_q} : '0);
    div_shl = {acc_q, 1'b0};
    div_top = div_shl[2*WIDTH:WIDTH];
    if (is_div_q) begin
      // Restoring step: subtract only when the shifted remainder covers the divisor.
      if (div_top >= {1'b0, dsor_q}) begin
        acc_d = {WIDTH'(div_top - {1'b0, dsor_q}), div_shl[WIDTH-1:1], 1'b1};
      end else begin
        acc_d = {div_shl[2*WIDTH-1:WIDTH], div_shl[WIDTH-1:1], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      fix_lo = dz_q ? '1 : (neg_q ? -quo : quo);
      fix_hi = neg_rem_q ? -rem : rem;
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dsor_q    <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            is_div_q  <= op_div;
            neg_q     <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= op_sgn & op_div & a[WIDTH-1];
            dz_q      <= op_div & (b == '0);
            div0_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            dsor_q    <= op_div ? b_mag : a_mag;
            if (early) begin
              // Skipped iterations: preload what the full run would have produced.
              acc_q   <= op_div ? {a_mag, {WIDTH{1'b1}}} : '0;
              state_q <= S_FIX;
            end else begin
              acc_q   <= op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          div0_q  <= dz_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, per-cycle compare, directed vectors.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  bit cmp_en   = 1'b0;

  // Reference model state
  bit           m_active = 1'b0;
  int           m_cur = 0, m_len = W + 2;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  bit           m_div0 = 1'b0, r_dz = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
    longint sx, sy, q, r;
    logic [63:0] p;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (y == '0) begin
          dz = 1'b1; h = x; l = '1;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          l = q[31:0]; h = r[31:0];
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] ? (y == '0) : (x == '0 || y == '0)) return 2;
`endif
    return W + 2;
  endfunction

  // Architectural model: counts cycles since acceptance; results land at the end of cycle len-1.
  always @(posedge clk) begin
    bit acc_now;
    if (rst) begin
      m_active = 1'b0; m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    end else begin
      acc_now = !m_active && start;
      if (!m_active || m_cur == m_len) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
      if (m_active) begin
        if (m_cur == m_len - 1) begin
          m_hi = r_hi; m_lo = r_lo; m_div0 = r_dz;
        end
        if (m_cur == m_len) m_active = 1'b0;
        else m_cur++;
      end
      if (acc_now) begin
        calc(op, a, b, r_hi, r_lo, r_dz);
        m_len    = exp_lat(op, a, b);
        m_active = 1'b1;
        m_cur    = 1;
        m_div0   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_active && m_cur < m_len);
      check("done", done, m_active && m_cur == m_len);
      check("div0", div0, m_div0);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; t0 = cyc;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int nb);
    bit seen = 1'b0;
    nb  = 0;
    lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) lat = cyc - t0 + 1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int nb);
    issue(o, x, y);
    wait_done(lat, nb);
  endtask

  initial begin
    int lat, nb, ndone;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
    $display("MULTU ffffffff*ffffffff: hi=%h lo=%h lat=%0d busy_cycles=%0d", hi, lo, lat, nb);
    check("multu_lat", lat, 34);
    check("multu_busy_cycles", nb, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, lat, nb);
    $display("MULT -7*3: hi=%h lo=%h", hi, lo);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb);
    $display("DIV -7/2: hi=%h lo=%h", hi, lo);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b11, 32'd100, 32'd7, lat, nb);
    $display("DIVU 100/7: hi=%h lo=%h", hi, lo);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(2'b11, 32'h1234, 32'd0, lat, nb);
    $display("DIVU 0x1234/0: hi=%h lo=%h div0=%b lat=%0d", hi, lo, div0, lat);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234);
    check("div0_flag", div0, 1);
`ifdef MULDIV_EARLY_OUT_EN
    check("div0_lat", lat, 2);
`else
    check("div0_lat", lat, 34);
`endif

    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, nb);
    $display("DIV -5/0: hi=%h lo=%h div0=%b", hi, lo, div0);
    check("sdiv0_lo", lo, 32'hFFFF_FFFF);
    check("sdiv0_hi", hi, 32'hFFFF_FFFB);

    @(posedge clk); #1 hi_we = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1 hi_we = 1'b0;
    @(negedge clk);
    $display("MTHI 0xaa: hi=%h", hi);
    check("mthi_hi", hi, 32'hAA);
    check("mthi_div0_sticky", div0, 1);

    issue(2'b00, 32'd3, 32'd4);
    check("mult_clears_div0", div0, 0);
    while (cyc < t0 + 9) @(posedge clk);
    #1 start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; lo_we = 1'b1; wdata = 32'h55;
    @(posedge clk); #1 start = 1'b0; lo_we = 1'b0;
    wait_done(lat, nb);
    $display("MULT 3*4 with ignored start/MTLO: hi=%h lo=%h lat=%0d", hi, lo, lat);
    check("busy_ign_lat", lat, 34);
    check("busy_ign_hi", hi, 32'd0);
    check("busy_ign_lo", lo, 32'd12);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("busy_ign_extra_done", ndone, 0);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    while (cyc < t0 + 14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("reset mid-DIV: busy=%b hi=%h lo=%h", busy, hi, lo);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
    $display("DIV 0x80000000/-1: hi=%h lo=%h div0=%b", hi, lo, div0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    check("ovf_div0", div0, 0);

    run_op(2'b01, 32'd0, 32'd5, lat, nb);
    $display("MULTU 0*5: hi=%h lo=%h lat=%0d", hi, lo, lat);
    check("mul0_lo", lo, 32'd0);
`ifdef MULDIV_EARLY_OUT_EN
    check("mul0_lat", lat, 2);
`else
    check("mul0_lat", lat, 34);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the CPU datapath; implements MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers.
- hi/lo feed the writeback-select multiplexer directly, for MFHI/MFLO.
- busy stalls the front end while an operation is in flight.

Parameters:
- WIDTH, 32: operand and HI/LO width. Iteration count equals WIDTH. Counter width is $clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high from the cycle after start is accepted through the FIX cycle
- done  out  1  one-cycle pulse; results are valid
- div0  out  1  sticky until next accepted start; last divide had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
Reset:
- State = IDLE.
- busy=0, done=0, div0=0, hi=0, lo=0.
- Counter and internal registers = 0.
- Reset mid-operation aborts immediately; no partial result reaches hi/lo.

States:
- IDLE -> CALC when start=1.
  - On that edge, latch |a| and |b| for signed ops; raw a and b for unsigned ops.
  - Latch the result sign: mul sign = a^b MSB; quotient sign = a^b MSB; remainder sign = a MSB.
  - Clear the counter and div0.
- CALC: one iteration per edge, WIDTH edges.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After edge WIDTH, go to FIX.
- FIX: one edge.
  - Apply two's-complement sign correction.
  - Write hi/lo: mul hi=product[2W-1:W], lo=product[W-1:0]; div lo=quotient, hi=remainder.
  - Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
  - A start in the DONE cycle is ignored.

Timing:
- Start accepted at edge 0 -> busy is high for cycles 1..WIDTH+1 -> done high in cycle WIDTH+2 (34 for WIDTH=32).

Command and write rules:
- start while busy or DONE: ignored; no queuing.
- op, a and b are don't-care except on the accepting edge.
- hi_we/lo_we: honoured only in IDLE and DONE; ignored while busy.
- hi_we/lo_we on the same edge as an accepted start: the write is applied, then overwritten at FIX.
- hi/lo otherwise hold their value indefinitely.

Divide corner cases:
- Divide by zero (b==0): runs full latency; lo=all ones, hi=original a; div0=1.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV): lo=0x80000000, hi=0, div0=0; the natural result of the abs/negate path.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: IDLE -> FIX directly, skipping CALC, when the operation is MULT/MULTU with a==0 or b==0, or DIV/DIVU with b==0.
  - done arrives in cycle 2 instead of WIDTH+2.
  - Results are identical to the full path.
- Undefined: all operations take the fixed WIDTH+2 latency.

Test Plan:
1. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1..33.
2. MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
3. DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU a=100 b=7 -> lo=14, hi=2.
4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, div0=1. With MULDIV_EARLY_OUT_EN, done in cycle 2.
5. MTHI wdata=0xAA, then start MULT 3*4, with a second start and lo_we pulsed at cycle 10 -> second start and lo_we ignored. Final hi=0, lo=12, exactly one done pulse.
6. Start DIV a=0x80000000 b=-1, assert rst at cycle 15 -> busy=0, done never pulses, hi=lo=0. Re-issue after reset -> lo=0x80000000, hi=0.
